// File: rtl/cluster_periph_pkg.sv
// Shared constants and types for the cluster peripheral demultiplexer.
// The destination FIFO entry pairs a plug index with the master transaction ID.
package cluster_periph_pkg;

  localparam int SPER_EOC_ID         = 0;
  localparam int SPER_TIMER_ID       = 1;
  localparam int SPER_EVENT_U_ID     = 2;
  localparam int SPER_HWPE_ID        = 3;
  localparam int SPER_ICACHE_CTRL_ID = 4;
  localparam int SPER_DMA_ID         = 5;
  localparam int SPER_EXT_ID         = 6;
  localparam int NB_SPERIPH_DFLT     = 8;

  localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

  // Dest holds plug indices 0..15 plus the ERR index (up to 16).
  localparam int PERIPH_DEST_W = 5;
  localparam int PERIPH_ID_W   = 5;

  typedef struct packed {
    logic [PERIPH_DEST_W-1:0] dest;
    logic [PERIPH_ID_W-1:0]   id;
  } periph_dest_t;

endpackage

// File: rtl/periph_dest_fifo.sv
// Synchronous FIFO of outstanding-transaction destinations, with head and tail peek.
// Push is ignored when full, pop is ignored when empty.
module periph_dest_fifo
  import cluster_periph_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  periph_dest_t     i_data,
  output periph_dest_t     o_head,
  output periph_dest_t     o_tail,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  periph_dest_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  // Tail is the most recently pushed entry; DEPTH is a power of two so the pointer wraps.
  assign o_tail  = r_mem[r_wr_ptr - PTR_W'(1)];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cluster_periph_demux.sv
// Routes master requests to peripheral plugs by address slot and returns responses
// in request order; unmapped slots get a locally generated error response.
module cluster_periph_demux
  import cluster_periph_pkg::*;
#(
  parameter int NB_SPERIPH = NB_SPERIPH_DFLT,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 5,
  parameter int SLOT_LSB   = 10,
  parameter int SLOT_W     = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              m_req_i,
  input  logic [ADDR_W-1:0]                 m_add_i,
  input  logic                              m_wen_i,
  input  logic [DATA_W-1:0]                 m_wdata_i,
  input  logic [DATA_W/8-1:0]               m_be_i,
  input  logic [ID_W-1:0]                   m_id_i,
  output logic                              m_gnt_o,
  output logic                              m_r_valid_o,
  output logic [DATA_W-1:0]                 m_r_rdata_o,
  output logic                              m_r_opc_o,
  output logic [ID_W-1:0]                   m_r_id_o,
  output logic [NB_SPERIPH-1:0]             s_req_o,
  output logic [ADDR_W-1:0]                 s_add_o,
  output logic                              s_wen_o,
  output logic [DATA_W-1:0]                 s_wdata_o,
  output logic [DATA_W/8-1:0]               s_be_o,
  output logic [ID_W-1:0]                   s_id_o,
  input  logic [NB_SPERIPH-1:0]             s_gnt_i,
  input  logic [NB_SPERIPH-1:0]             s_r_valid_i,
  input  logic [NB_SPERIPH-1:0][DATA_W-1:0] s_r_rdata_i,
  input  logic [NB_SPERIPH-1:0]             s_r_opc_i,
  input  logic [NB_SPERIPH-1:0][ID_W-1:0]   s_r_id_i,
  output logic                              spurious_o
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam logic [PERIPH_DEST_W-1:0] DEST_ERR = PERIPH_DEST_W'(NB_SPERIPH);
  localparam logic [DATA_W-1:0] ERR_RDATA_W = DATA_W'(ERR_RDATA);

  logic [SLOT_W-1:0]        w_slot;
  logic [PERIPH_DEST_W-1:0] w_target;
  logic                     w_stall;
  logic                     w_pop;
  logic [NB_SPERIPH-1:0]    w_accept;
  periph_dest_t             w_push_data;
  periph_dest_t             w_head;
  periph_dest_t             w_tail;
  logic                     w_full;
  logic                     w_empty;
  logic [CNT_W-1:0]         w_count;

  assign s_add_o   = m_add_i;
  assign s_wen_o   = m_wen_i;
  assign s_wdata_o = m_wdata_i;
  assign s_be_o    = m_be_i;
  assign s_id_o    = m_id_i;

  assign w_slot = m_add_i[SLOT_LSB +: SLOT_W];

  always_comb begin
    w_target = DEST_ERR;
    if (int'(w_slot) < NB_SPERIPH) w_target = PERIPH_DEST_W'(w_slot);
  end

  // New requests must target the tail's plug so two plugs never race to answer out of order.
  assign w_stall = (w_count == CNT_W'(MAX_OUTST)) || (!w_empty && (w_tail.dest != w_target));

  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (!rst_i && !w_stall) begin
      if (w_target == DEST_ERR) begin
        m_gnt_o = m_req_i;
      end else begin
        for (int p = 0; p < NB_SPERIPH; p++) begin
          if (w_target == PERIPH_DEST_W'(p)) begin
            s_req_o[p] = m_req_i;
            m_gnt_o    = m_req_i && s_gnt_i[p];
          end
        end
      end
    end
  end

  assign w_push_data.dest = w_target;
  assign w_push_data.id   = PERIPH_ID_W'(m_id_i);

  always_comb begin
    m_r_valid_o = 1'b0;
    m_r_rdata_o = '0;
    m_r_opc_o   = 1'b0;
    m_r_id_o    = '0;
    w_accept    = '0;
    w_pop       = 1'b0;
    if (!w_empty) begin
      if (w_head.dest == DEST_ERR) begin
        m_r_valid_o = 1'b1;
        m_r_rdata_o = ERR_RDATA_W;
        m_r_opc_o   = 1'b1;
        m_r_id_o    = ID_W'(w_head.id);
        w_pop       = 1'b1;
      end else begin
        for (int p = 0; p < NB_SPERIPH; p++) begin
          if (w_head.dest == PERIPH_DEST_W'(p)) begin
            w_accept[p] = 1'b1;
            if (s_r_valid_i[p]) begin
              m_r_valid_o = 1'b1;
              m_r_rdata_o = s_r_rdata_i[p];
              m_r_opc_o   = s_r_opc_i[p];
              m_r_id_o    = s_r_id_i[p];
              w_pop       = 1'b1;
            end
          end
        end
      end
    end
  end

  // Any slave response not owed by the FIFO head is dropped and flagged.
  assign spurious_o = !rst_i && |(s_r_valid_i & ~w_accept);

  periph_dest_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_dest_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (m_gnt_o),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Full is also derived from the count above; both must agree.
  logic w_full_unused;
  assign w_full_unused = w_full;

endmodule

// File: tb/tb_cluster_periph_demux.sv
// Directed bench for cluster_periph_demux: a vector table of single transactions
// followed by hand-written multi-cycle sequences for stalls, fullness and resets.
module tb_cluster_periph_demux;

  localparam int NB = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_req;
  logic [31:0]     m_add;
  logic            m_wen;
  logic [31:0]     m_wdata;
  logic [3:0]      m_be;
  logic [4:0]      m_id;
  logic            m_gnt;
  logic            m_r_valid;
  logic [31:0]     m_r_rdata;
  logic            m_r_opc;
  logic [4:0]      m_r_id;
  logic [NB-1:0]   s_req;
  logic [31:0]     s_add;
  logic            s_wen;
  logic [31:0]     s_wdata;
  logic [3:0]      s_be;
  logic [4:0]      s_id;
  logic [NB-1:0]   s_gnt;
  logic [NB-1:0]   s_r_valid;
  logic [NB-1:0][31:0] s_r_rdata;
  logic [NB-1:0]   s_r_opc;
  logic [NB-1:0][4:0] s_r_id;
  logic            spurious;

  int n_cmp = 0;
  int n_err = 0;

  cluster_periph_demux dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m_req_i     (m_req),
    .m_add_i     (m_add),
    .m_wen_i     (m_wen),
    .m_wdata_i   (m_wdata),
    .m_be_i      (m_be),
    .m_id_i      (m_id),
    .m_gnt_o     (m_gnt),
    .m_r_valid_o (m_r_valid),
    .m_r_rdata_o (m_r_rdata),
    .m_r_opc_o   (m_r_opc),
    .m_r_id_o    (m_r_id),
    .s_req_o     (s_req),
    .s_add_o     (s_add),
    .s_wen_o     (s_wen),
    .s_wdata_o   (s_wdata),
    .s_be_o      (s_be),
    .s_id_o      (s_id),
    .s_gnt_i     (s_gnt),
    .s_r_valid_i (s_r_valid),
    .s_r_rdata_i (s_r_rdata),
    .s_r_opc_i   (s_r_opc),
    .s_r_id_i    (s_r_id),
    .spurious_o  (spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  id;
    logic        sgnt;
    int          rplug;
    logic [31:0] rdata;
    logic        ropc;
    logic        exp_gnt;
    logic [7:0]  exp_sreq;
    logic        exp_rv;
    logic [31:0] exp_rdata;
    logic        exp_opc;
    logic [4:0]  exp_id;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_req     = 1'b0;
    m_add     = '0;
    m_id      = '0;
    s_gnt     = '0;
    s_r_valid = '0;
    s_r_rdata = '0;
    s_r_opc   = '0;
    s_r_id    = '0;
  endtask

  task automatic slave_resp(input int p, input logic [31:0] data, input logic opc, input logic [4:0] id);
    s_r_valid[p] = 1'b1;
    s_r_rdata[p] = data;
    s_r_opc[p]   = opc;
    s_r_id[p]    = id;
  endtask

  task automatic request(input logic [31:0] addr, input logic [4:0] id);
    m_req = 1'b1;
    m_add = addr;
    m_id  = id;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0400, 5'd3,  1'b1,  1, 32'h0000_1234, 1'b0, 1'b1, 8'h02, 1'b1, 32'h0000_1234, 1'b0, 5'd3};
    vecs[1] = '{32'h0000_3000, 5'd7,  1'b1, -1, 32'h0,         1'b0, 1'b1, 8'h00, 1'b1, 32'hBADACCE5, 1'b1, 5'd7};
    vecs[2] = '{32'h0000_1C04, 5'h1F, 1'b1,  7, 32'hDEADBEEF,  1'b1, 1'b1, 8'h80, 1'b1, 32'hDEADBEEF, 1'b1, 5'h1F};
    vecs[3] = '{32'h0000_2000, 5'd2,  1'b1, -1, 32'h0,         1'b0, 1'b1, 8'h00, 1'b1, 32'hBADACCE5, 1'b1, 5'd2};
    vecs[4] = '{32'h0000_0000, 5'd4,  1'b0, -1, 32'h0,         1'b0, 1'b0, 8'h01, 1'b0, 32'h0,         1'b0, 5'd0};
    vecs[5] = '{32'h0000_0C00, 5'd4,  1'b1,  3, 32'h0000_00A5, 1'b0, 1'b1, 8'h08, 1'b1, 32'h0000_00A5, 1'b0, 5'd4};
    vecs[6] = '{32'hFFFF_3C00, 5'd9,  1'b1, -1, 32'h0,         1'b0, 1'b1, 8'h00, 1'b1, 32'hBADACCE5, 1'b1, 5'd9};
    vecs[7] = '{32'h0000_17FC, 5'h11, 1'b1,  5, 32'h5555_AAAA, 1'b0, 1'b1, 8'h20, 1'b1, 32'h5555_AAAA, 1'b0, 5'h11};

    m_wen   = 1'b1;
    m_wdata = 32'h0;
    m_be    = 4'hF;
    idle();
    rst = 1'b1;

    // Reset: outputs held low even with a live request and a stray response.
    request(32'h0000_0400, 5'd1);
    s_gnt = '1;
    s_r_valid[3] = 1'b1;
    #3;
    chk("rst_gnt",      m_gnt,     0);
    chk("rst_sreq",     s_req,     0);
    chk("rst_rvalid",   m_r_valid, 0);
    chk("rst_spurious", spurious,  0);
    cycle();
    rst = 1'b0;
    idle();

    // Single-transaction table.
    for (int i = 0; i < 8; i++) begin
      cycle();
      request(vecs[i].addr, vecs[i].id);
      s_gnt = vecs[i].sgnt ? '1 : '0;
      #2;
      chk($sformatf("v%0d_gnt", i),  m_gnt, vecs[i].exp_gnt);
      chk($sformatf("v%0d_sreq", i), s_req, vecs[i].exp_sreq);
      cycle();
      idle();
      if (vecs[i].rplug >= 0) slave_resp(vecs[i].rplug, vecs[i].rdata, vecs[i].ropc, vecs[i].id);
      #2;
      chk($sformatf("v%0d_rvalid", i), m_r_valid, vecs[i].exp_rv);
      chk($sformatf("v%0d_rdata", i),  m_r_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_opc", i),    m_r_opc,   vecs[i].exp_opc);
      chk($sformatf("v%0d_rid", i),    m_r_id,    vecs[i].exp_id);
      chk($sformatf("v%0d_spur", i),   spurious,  0);
      cycle();
      idle();
    end

    // Cross-plug stall: slot 6 waits until the slot 2 response has popped.
    cycle();
    request(32'h0000_0800, 5'd1);
    s_gnt = '1;
    #2 chk("stall_g2", m_gnt, 1);
    for (int c = 0; c < 2; c++) begin
      cycle();
      request(32'h0000_1800, 5'd2);
      #2;
      chk("stall_g6_wait", m_gnt, 0);
      chk("stall_sreq",    s_req, 0);
    end
    cycle();
    slave_resp(2, 32'h22, 1'b0, 5'd1);
    #2;
    chk("stall_r2_valid", m_r_valid, 1);
    chk("stall_r2_data",  m_r_rdata, 32'h22);
    chk("stall_pop_gnt",  m_gnt,     0);
    cycle();
    s_r_valid = '0;
    #2;
    chk("stall_g6_gnt",  m_gnt, 1);
    chk("stall_g6_sreq", s_req, 8'h40);
    cycle();
    idle();
    slave_resp(6, 32'h66, 1'b0, 5'd2);
    #2;
    chk("stall_r6_valid", m_r_valid, 1);
    chk("stall_r6_data",  m_r_rdata, 32'h66);
    chk("stall_r6_id",    m_r_id,    5'd2);
    cycle();
    idle();

    // Fill to MAX_OUTST, then a same-cycle pop must not admit the fifth request.
    s_gnt = '1;
    for (int k = 0; k < 4; k++) begin
      request(32'h0, 5'(k));
      #2 chk($sformatf("full_g%0d", k), m_gnt, 1);
      cycle();
    end
    request(32'h0, 5'd4);
    #2 chk("full_block", m_gnt, 0);
    cycle();
    slave_resp(0, 32'h100, 1'b0, 5'd0);
    #2;
    chk("full_pop_valid", m_r_valid, 1);
    chk("full_pop_nogt",  m_gnt,     0);
    cycle();
    s_r_valid = '0;
    #2;
    chk("full_admit",  m_gnt,     1);
    chk("full_norv",   m_r_valid, 0);
    cycle();
    m_req = 1'b0;
    for (int k = 1; k < 5; k++) begin
      slave_resp(0, 32'h100 + k, 1'b0, 5'(k));
      #2;
      chk($sformatf("drain%0d_valid", k), m_r_valid, 1);
      chk($sformatf("drain%0d_data", k),  m_r_rdata, 32'h100 + k);
      cycle();
    end
    slave_resp(0, 32'h1FF, 1'b0, 5'd0);
    #2;
    chk("drained_spur",   spurious,  1);
    chk("drained_norv",   m_r_valid, 0);
    cycle();
    idle();

    // Back-to-back error entries return one per cycle.
    request(32'h0000_3000, 5'd5);
    #2 chk("err2_g0", m_gnt, 1);
    cycle();
    request(32'h0000_3400, 5'd6);
    #2;
    chk("err2_g1",    m_gnt,     1);
    chk("err2_r0_v",  m_r_valid, 1);
    chk("err2_r0_id", m_r_id,    5'd5);
    cycle();
    idle();
    #2;
    chk("err2_r1_v",  m_r_valid, 1);
    chk("err2_r1_id", m_r_id,    5'd6);
    cycle();
    #2 chk("err2_done", m_r_valid, 0);

    // Spurious responses: FIFO empty, then a non-head plug.
    cycle();
    slave_resp(3, 32'h33, 1'b0, 5'd0);
    #2;
    chk("spur_empty",    spurious,  1);
    chk("spur_empty_rv", m_r_valid, 0);
    cycle();
    idle();
    request(32'h0000_0400, 5'd9);
    s_gnt = '1;
    #2 chk("spur_push_gnt", m_gnt, 1);
    cycle();
    idle();
    slave_resp(4, 32'h44, 1'b0, 5'd9);
    #2;
    chk("spur_other",    spurious,  1);
    chk("spur_other_rv", m_r_valid, 0);
    cycle();
    idle();
    slave_resp(1, 32'h11, 1'b0, 5'd9);
    #2;
    chk("spur_head_rv",   m_r_valid, 1);
    chk("spur_head_none", spurious,  0);
    cycle();
    idle();

    // Reset with two outstanding entries discards them.
    s_gnt = '1;
    request(32'h0000_1400, 5'd1);
    #2 chk("rst2_g0", m_gnt, 1);
    cycle();
    request(32'h0000_1400, 5'd2);
    #2 chk("rst2_g1", m_gnt, 1);
    cycle();
    rst = 1'b1;
    #2;
    chk("rst2_gnt",  m_gnt, 0);
    chk("rst2_sreq", s_req, 0);
    cycle();
    rst = 1'b0;
    idle();
    cycle();
    slave_resp(5, 32'h55, 1'b0, 5'd1);
    #2;
    chk("rst2_spur", spurious,  1);
    chk("rst2_norv", m_r_valid, 0);
    cycle();
    idle();
    request(32'h0000_3000, 5'd3);
    #2 chk("rst2_err_gnt", m_gnt, 1);
    cycle();
    idle();
    #2;
    chk("rst2_err_rv",   m_r_valid, 1);
    chk("rst2_err_data", m_r_rdata, 32'hBADACCE5);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cluster_periph_demux.md
# cluster_periph_demux

Parametrised request/response demultiplexer between one cluster peripheral-interconnect master port and `NB_SPERIPH` peripheral slave plugs (EOC, timer, event unit, HWPE, icache ctrl, DMA, ext). It replaces fixed per-ID wiring with a decoded slot field, tracks outstanding transactions in a destination FIFO so responses return to the master strictly in request order, and answers accesses to unmapped slots with a locally generated error response. It sits between the cluster peripheral interconnect and the peripheral plugs.

## Interface
- `NB_SPERIPH`, 8: number of slave plugs; slot s maps to port s for s < NB_SPERIPH.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `ID_W`, 5: transaction ID width.
- `SLOT_LSB`, 10: lowest address bit of the slot field (1 KiB per peripheral).
- `SLOT_W`, 4: slot field width; NB_SPERIPH <= 2**SLOT_W.
- `MAX_OUTST`, 4: destination FIFO depth (power of two, >= 2).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `m_req_i` in 1; `m_add_i` in ADDR_W; `m_wen_i` in 1 (1 = read); `m_wdata_i` in DATA_W; `m_be_i` in DATA_W/8; `m_id_i` in ID_W: master request.
- `m_gnt_o` out 1: request accepted this cycle.
- `m_r_valid_o` out 1; `m_r_rdata_o` out DATA_W; `m_r_opc_o` out 1 (1 = error); `m_r_id_o` out ID_W: master response.
- `s_req_o` out [NB_SPERIPH]; `s_add_o`, `s_wen_o`, `s_wdata_o`, `s_be_o`, `s_id_o` out, broadcast to all plugs.
- `s_gnt_i` in [NB_SPERIPH]; `s_r_valid_i` in [NB_SPERIPH]; `s_r_rdata_i`, `s_r_opc_i`, `s_r_id_i` in, per plug.
- `spurious_o` out 1: one-cycle pulse on a slave r_valid not matching FIFO head.

## Operation
- Decode: slot = m_add_i[SLOT_LSB+SLOT_W-1:SLOT_LSB]; target = slot if slot < NB_SPERIPH, else ERR (internal index NB_SPERIPH).
- Stall when: FIFO full (registered count == MAX_OUTST), or FIFO non-empty and target != tail destination (prevents cross-plug reordering).
- Not stalled, target mapped: s_req_o[target] = m_req_i; m_gnt_o = s_gnt_i[target]; other s_req_o bits 0.
- Not stalled, target ERR: m_gnt_o = m_req_i, no s_req_o asserted.
- Each grant pushes {target, m_id_i} into the FIFO.
- Response: head mapped → m_r_* = slave head fields combinationally when s_r_valid_i[head]; pop on that cycle. Head ERR → m_r_valid_o=1, m_r_opc_o=1, m_r_rdata_o=ERR_RDATA (32'hBADACCE5, zero-extended/truncated to DATA_W), m_r_id_o = stored ID; earliest cycle after grant; pop.
- At most one pop and one push per cycle; push and pop same cycle keep count unchanged. Full check uses registered count (no same-cycle bypass).
- s_r_valid_i on a non-head plug, or any when FIFO empty: ignored, spurious_o pulses.
- Outside responses, m_r_* data outputs are 0.

## Timing
- Reset: FIFO empty, count 0, m_gnt_o/m_r_valid_o/spurious_o 0, s_req_o all 0 (combinational from m_req_i gated by state). Reset mid-transaction discards outstanding entries; later slave responses raise spurious_o.
- Request path combinational, 0 cycles: m_req_i → s_req_o, s_gnt_i → m_gnt_o.
- Mapped response path combinational, 0 cycles.
- Error response: FIFO registered; r_valid at earliest 1 cycle after grant, back-to-back ERR entries return one per cycle.
- Throughput: one request per cycle to a single plug with 1-cycle slaves and MAX_OUTST >= 2.

## Structure
- Package `cluster_periph_pkg`: SPER_*_ID slot constants, NB_SPERIPH default, ERR_RDATA, `periph_dest_t` struct {dest, id}.
- Sub-module `periph_dest_fifo`: MAX_OUTST-deep synchronous FIFO of `periph_dest_t` with full/empty/count and tail peek.

## Test plan
- Read to slot 1 (addr 0x0000_0400), slave gnt same cycle, r_valid next cycle rdata 0x1234 → m_gnt_o same cycle, m_r_rdata_o=0x1234, opc 0, ID echoed.
- Read to slot 12 (addr 0x0000_3000, NB_SPERIPH=8) → m_gnt_o immediate, 1 cycle later r_valid, opc 1, rdata 0xBADACCE5, no s_req_o asserted.
- Slot 2 then slot 6 back-to-back, slot 2 response delayed 3 cycles → slot 6 request stalled (gnt 0) until slot 2 response pops; responses in order.
- Slave never responds, 4 grants to slot 0 (MAX_OUTST=4) → 5th request gnt 0 until one response; same-cycle pop does not admit it.
- r_valid from plug 3 while FIFO empty → spurious_o pulse, m_r_valid_o 0.
- rst_i asserted with 2 outstanding, then late slave r_valid → state empty, spurious_o pulse, no master response.
